// File: rtl/fifo_pkg.sv
// Shared types and helpers for the first-word-fall-through FIFO.
// Optional error flags are enabled by defining FIFO_ERR_FLAGS_EN.
package fifo_pkg;

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_t;

    localparam int DEF_DEPTH     = 32;
    localparam int DEF_AE_THRESH = 4;
    localparam int DEF_AF_MARGIN = 4;

    // Pointer width for a power-of-two depth, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array behind the FIFO head register.
// Synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are meaningless until written,
    // and omitting the reset lets synthesis map it onto plain storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft.sv
// Synchronous FWFT FIFO: registered head word on dout, remaining words in fifo_ram.
// Defining FIFO_ERR_FLAGS_EN adds err_clr and sticky overflow/underflow flags.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    head_state_t      head_state;
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [WIDTH-1:0] ram_rdata;
    logic             push;
    logic             pop;
    logic             ram_empty;
    logic             bypass;
    logic             ram_we;

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // The RAM never holds more than DEPTH-1 words (one lives in the head),
    // so equal pointers can only mean the RAM is empty.
    assign ram_empty = (wp == rp);
    assign bypass    = push && ((head_state == HEAD_EMPTY) || (pop && ram_empty));
    assign ram_we    = push && !bypass;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wp),
        .wdata (din),
        .raddr (rp),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_state <= HEAD_EMPTY;
            dout       <= '0;
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
        end else begin
            if (ram_we) begin
                wp <= wp + PW'(1);
            end

            case (head_state)
                HEAD_EMPTY: begin
                    if (push) begin
                        dout       <= din;
                        head_state <= HEAD_VALID;
                    end
                end
                HEAD_VALID: begin
                    if (pop) begin
                        if (!ram_empty) begin
                            dout <= ram_rdata;
                            rp   <= rp + PW'(1);
                        end else if (push) begin
                            dout <= din;
                        end else begin
                            head_state <= HEAD_EMPTY;
                        end
                    end
                end
                default: head_state <= HEAD_EMPTY;
            endcase

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // A new error in the same cycle as err_clr takes priority over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// Self-checking bench for fifo_fwft: fixed vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_fifo_fwft;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AF_TH = DEPTH - 4;
    localparam int AE_TH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;
`endif

    fifo_fwft #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_TH),
        .AE_THRESH (AE_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .dout         (dout),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: contents in arrival order, oldest at index 0.
    logic [WIDTH-1:0] q[$];

    typedef struct {
        string            name;
        bit               wr;
        bit               rd;
        logic [WIDTH-1:0] data;
        int               exp_count;
        bit               exp_empty;
        logic [WIDTH-1:0] exp_dout;
        bit               chk_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n = q.size();
        check({tag, ".count"},        int'(count),        n);
        check({tag, ".empty"},        int'(empty),        int'(n == 0));
        check({tag, ".full"},         int'(full),         int'(n == DEPTH));
        check({tag, ".almost_empty"}, int'(almost_empty), int'(n <= AE_TH));
        check({tag, ".almost_full"},  int'(almost_full),  int'(n >= AF_TH));
        if (n > 0) begin
            check({tag, ".dout"}, int'(dout), int'(q[0]));
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input string tag, input bit we, input logic [WIDTH-1:0] d, input bit re);
        int  n;
        bit  push_ok;
        bit  pop_ok;
        wr_en = we;
        din   = d;
        rd_en = re;
        @(posedge clk);
        n       = q.size();
        push_ok = we && (n < DEPTH);
        pop_ok  = re && (n > 0);
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) begin
            step(tag, 1'b0, '0, 1'b1);
        end
        check({tag, ".drained"}, int'(empty), 1);
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset state, including the head register value.
        check("rst.count", int'(count), 0);
        check("rst.empty", int'(empty), 1);
        check("rst.full", int'(full), 0);
        check("rst.almost_empty", int'(almost_empty), 1);
        check("rst.almost_full", int'(almost_full), 0);
        check("rst.dout", int'(dout), 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst.overflow", int'(overflow), 0);
        check("rst.underflow", int'(underflow), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Fixed vectors: single push/pop, ignored pop, simultaneous on empty.
        vecs[0] = '{"v0.push_a5",       1, 0, 8'hA5, 1, 0, 8'hA5, 1};
        vecs[1] = '{"v1.pop_a5",        0, 1, 8'h00, 0, 1, 8'h00, 0};
        vecs[2] = '{"v2.pop_on_empty",  0, 1, 8'h00, 0, 1, 8'h00, 0};
        vecs[3] = '{"v3.both_on_empty", 1, 1, 8'h3C, 1, 0, 8'h3C, 1};
        vecs[4] = '{"v4.both_count1",   1, 1, 8'h3D, 1, 0, 8'h3D, 1};
        vecs[5] = '{"v5.push_behind",   1, 0, 8'h3E, 2, 0, 8'h3D, 1};
        vecs[6] = '{"v6.pop_from_ram",  0, 1, 8'h00, 1, 0, 8'h3E, 1};
        vecs[7] = '{"v7.pop_last",      0, 1, 8'h00, 0, 1, 8'h00, 0};
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].name, vecs[i].wr, vecs[i].data, vecs[i].rd);
            check({vecs[i].name, ".tbl_count"}, int'(count), vecs[i].exp_count);
            check({vecs[i].name, ".tbl_empty"}, int'(empty), int'(vecs[i].exp_empty));
            if (vecs[i].chk_dout) begin
                check({vecs[i].name, ".tbl_dout"}, int'(dout), int'(vecs[i].exp_dout));
            end
        end

        // Fill to capacity; the model tracks almost_full crossing at 28.
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, WIDTH'(i), 1'b0);
            check("fill.almost_full_edge", int'(almost_full), int'((i + 1) >= 28));
        end
        check("fill.full", int'(full), 1);
        step("push_when_full", 1'b1, 8'hFF, 1'b0);
        check("push_when_full.count", int'(count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check("order.dout", int'(dout), i);
            step("order", 1'b0, '0, 1'b1);
        end
        check("order.empty", int'(empty), 1);

        // Full with simultaneous push and pop: only the pop takes effect.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, WIDTH'(8'h40 + i), 1'b0);
        step("both_on_full", 1'b1, 8'hEE, 1'b1);
        check("both_on_full.count", int'(count), DEPTH - 1);
        drain("drain_full");

        // Count held at 1 with continuous push+pop: dout follows din by one edge.
        step("stream_prime", 1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            step("stream", 1'b1, WIDTH'(i), 1'b1);
            check("stream.dout", int'(dout), i & 8'hFF);
            check("stream.count", int'(count), 1);
        end
        drain("drain_stream");

        // Around half full for 3*DEPTH cycles so both pointers wrap.
        for (int i = 0; i < DEPTH / 2; i++) step("half_fill", 1'b1, WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step("half_rand", 1'b1, WIDTH'($urandom), 1'b1);
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step("half_mix", 1'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        drain("drain_half");

        // Longer random traffic with shifting push/pop bias to hit both ends.
        for (int blk = 0; blk < 16; blk++) begin
            int wr_pct = (blk % 4 == 0) ? 85 : (blk % 4 == 1) ? 15 : 50;
            for (int i = 0; i < 100; i++) begin
                step("rand",
                     $urandom_range(99) < wr_pct,
                     WIDTH'($urandom),
                     $urandom_range(99) < (100 - wr_pct));
            end
        end
        drain("drain_rand");

        // Asynchronous reset with 17 words held: outputs clear before any edge.
        for (int i = 0; i < 17; i++) step("pre_arst", 1'b1, WIDTH'(8'h80 + i), 1'b0);
        check("pre_arst.count", int'(count), 17);
        #1 rst = 1'b1;
        #1;
        check("arst.count", int'(count), 0);
        check("arst.empty", int'(empty), 1);
        check("arst.full", int'(full), 0);
        check("arst.almost_empty", int'(almost_empty), 1);
        check("arst.almost_full", int'(almost_full), 0);
        check("arst.dout", int'(dout), 0);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        step("post_arst", 1'b1, 8'h11, 1'b0);
        step("post_arst2", 1'b0, '0, 1'b1);

`ifdef FIFO_ERR_FLAGS_EN
        step("uf_pop", 1'b0, '0, 1'b1);
        check("underflow.set", int'(underflow), 1);
        step("uf_hold", 1'b0, '0, 1'b0);
        check("underflow.hold", int'(underflow), 1);
        err_clr = 1'b1;
        step("uf_clr", 1'b0, '0, 1'b0);
        err_clr = 1'b0;
        check("underflow.clear", int'(underflow), 0);
        for (int i = 0; i < DEPTH; i++) step("of_fill", 1'b1, WIDTH'(i), 1'b0);
        check("overflow.not_yet", int'(overflow), 0);
        step("of_push", 1'b1, 8'h99, 1'b0);
        check("overflow.set", int'(overflow), 1);
        err_clr = 1'b1;
        step("of_set_wins", 1'b1, 8'h9A, 1'b0);
        err_clr = 1'b0;
        check("overflow.set_wins", int'(overflow), 1);
        drain("drain_err");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
